// File: rtl/sha_pkg.sv
// Shared SHA-2 sigma definitions: function selector, rotate/shift amounts
// for SHA-256 and SHA-512, and a width-aware circular rotate.
package sha_pkg;

    typedef enum logic [1:0] {
        SIG0  = 2'd0,
        SIG1  = 2'd1,
        BSIG0 = 2'd2,
        BSIG1 = 2'd3
    } sigma_mode_t;

    // Each row is {term_a, term_b, term_c}, indexed by sigma_mode_t.
    // For SIG0/SIG1 the third amount is a logical right shift; for
    // BSIG0/BSIG1 all three amounts are rotations.
    localparam int unsigned SHA256_AMT [4][3] = '{
        '{7,  18, 3 },
        '{17, 19, 10},
        '{2,  13, 22},
        '{6,  11, 25}
    };

    localparam int unsigned SHA512_AMT [4][3] = '{
        '{1,  8,  7 },
        '{19, 61, 6 },
        '{28, 34, 39},
        '{14, 18, 41}
    };

    // Circular right rotate within w bits (w is 32 or 64). For w=32 the
    // operand lives in bits [31:0] and the upper half of the result is zero.
    // Amounts are always in 1..w-1, so neither shift degenerates.
    function automatic logic [63:0] rotr(input logic [63:0] x,
                                         input int unsigned n,
                                         input int unsigned w);
        logic [31:0] lo;
        lo = x[31:0];
        if (w == 64) begin
            rotr = (x >> n) | (x << (64 - n));
        end else begin
            rotr = {32'd0, (lo >> n) | (lo << (32 - n))};
        end
    endfunction

endpackage

// File: rtl/sigma_func.sv
// Combinational SHA-2 sigma evaluator: produces the three rotated/shifted
// terms of the selected function and their XOR.
module sigma_func
    import sha_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        mode,
    output logic [WORD_W-1:0] term_a,
    output logic [WORD_W-1:0] term_b,
    output logic [WORD_W-1:0] term_c,
    output logic [WORD_W-1:0] result
);

    logic [63:0]  wide;
    logic [63:0]  ra_full;
    logic [63:0]  rb_full;
    logic [63:0]  rc_full;
    int unsigned  amt_a;
    int unsigned  amt_b;
    int unsigned  amt_c;
    sigma_mode_t  sel;
    logic         unused_hi;

    // Pick the amounts for the configured width, then form the three terms.
    always_comb begin
        wide = 64'(word);
        sel  = sigma_mode_t'(mode);
        if (WORD_W == 64) begin
            amt_a = SHA512_AMT[mode][0];
            amt_b = SHA512_AMT[mode][1];
            amt_c = SHA512_AMT[mode][2];
        end else begin
            amt_a = SHA256_AMT[mode][0];
            amt_b = SHA256_AMT[mode][1];
            amt_c = SHA256_AMT[mode][2];
        end
        ra_full = rotr(wide, amt_a, WORD_W);
        rb_full = rotr(wide, amt_b, WORD_W);
        // Small sigmas end in a zero-filling shift, big sigmas in a rotate.
        if (sel == SIG0 || sel == SIG1) begin
            rc_full = wide >> amt_c;
        end else begin
            rc_full = rotr(wide, amt_c, WORD_W);
        end
    end

    assign term_a = ra_full[WORD_W-1:0];
    assign term_b = rb_full[WORD_W-1:0];
    assign term_c = rc_full[WORD_W-1:0];
    assign result = term_a ^ term_b ^ term_c;

    // For 32-bit words the upper halves of the 64-bit scratch values are zero.
    assign unused_hi = ^{ra_full, rb_full, rc_full, wide};

endmodule

// File: rtl/sigma_unit.sv
// SHA-2 sigma engine with a valid/ready pipeline of depth 1 or 2 and a
// sideband tag/mode that travel with each result.
module sigma_unit
    import sha_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int PIPE   = 1,
    parameter int TAG_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic [1:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [TAG_W-1:0]  out_tag,
    output logic [1:0]        out_mode
);

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
        $error("sigma_unit: WORD_W must be 32 or 64");
    end
    if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
        $error("sigma_unit: PIPE must be 1 or 2");
    end

    logic [WORD_W-1:0] term_a;
    logic [WORD_W-1:0] term_b;
    logic [WORD_W-1:0] term_c;
    logic [WORD_W-1:0] func_result;

    sigma_func #(
        .WORD_W (WORD_W)
    ) u_func (
        .word   (in_word),
        .mode   (in_mode),
        .term_a (term_a),
        .term_b (term_b),
        .term_c (term_c),
        .result (func_result)
    );

    if (PIPE == 1) begin : g_pipe1
        logic              valid_reg;
        logic [WORD_W-1:0] word_reg;
        logic [TAG_W-1:0]  tag_reg;
        logic [1:0]        mode_reg;
        logic              unused_terms;

        assign unused_terms = ^{term_a, term_b, term_c};

        // The single stage can take a new entry when empty or draining now.
        assign in_ready = !valid_reg || out_ready;

        // Output stage: load the full XOR result on each input transfer.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                valid_reg <= 1'b0;
                word_reg  <= '0;
                tag_reg   <= '0;
                mode_reg  <= '0;
            end else if (in_ready) begin
                valid_reg <= in_valid;
                if (in_valid) begin
                    word_reg <= func_result;
                    tag_reg  <= in_tag;
                    mode_reg <= in_mode;
                end
            end
        end

        assign out_valid = valid_reg;
        assign out_word  = word_reg;
        assign out_tag   = tag_reg;
        assign out_mode  = mode_reg;
    end else begin : g_pipe2
        logic              s1_valid_reg;
        logic [WORD_W-1:0] s1_a_reg;
        logic [WORD_W-1:0] s1_b_reg;
        logic [WORD_W-1:0] s1_c_reg;
        logic [TAG_W-1:0]  s1_tag_reg;
        logic [1:0]        s1_mode_reg;
        logic              s2_valid_reg;
        logic [WORD_W-1:0] s2_word_reg;
        logic [TAG_W-1:0]  s2_tag_reg;
        logic [1:0]        s2_mode_reg;
        logic              s1_ready;
        logic              s2_ready;
        logic              unused_result;

        assign unused_result = ^func_result;

        // Per-stage ready chain: a stage moves when empty or when the next
        // stage moves, so bubbles collapse and nothing depends on in_valid.
        assign s2_ready = !s2_valid_reg || out_ready;
        assign s1_ready = !s1_valid_reg || s2_ready;
        assign in_ready = s1_ready;

        // Stage 1 occupancy.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                s1_valid_reg <= 1'b0;
            end else if (s1_ready) begin
                s1_valid_reg <= in_valid;
            end
        end

        // Stage 1 payload: the three terms, unreset since valid guards them.
        always_ff @(posedge clock) begin
            if (in_valid && s1_ready) begin
                s1_a_reg    <= term_a;
                s1_b_reg    <= term_b;
                s1_c_reg    <= term_c;
                s1_tag_reg  <= in_tag;
                s1_mode_reg <= in_mode;
            end
        end

        // Stage 2 (output): fold the terms with XOR.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                s2_valid_reg <= 1'b0;
                s2_word_reg  <= '0;
                s2_tag_reg   <= '0;
                s2_mode_reg  <= '0;
            end else if (s2_ready) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_word_reg <= s1_a_reg ^ s1_b_reg ^ s1_c_reg;
                    s2_tag_reg  <= s1_tag_reg;
                    s2_mode_reg <= s1_mode_reg;
                end
            end
        end

        assign out_valid = s2_valid_reg;
        assign out_word  = s2_word_reg;
        assign out_tag   = s2_tag_reg;
        assign out_mode  = s2_mode_reg;
    end

endmodule

// File: tb/tb_sigma_unit.sv
// Scoreboard bench for sigma_unit: a 32-bit single-stage instance and a
// 64-bit two-stage instance, with a bit-level reference model.
module tb_sigma_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        in_valid32 = 1'b0;
    logic        in_ready32;
    logic [31:0] in_word32 = '0;
    logic [1:0]  in_mode32 = '0;
    logic [3:0]  in_tag32 = '0;
    logic        out_valid32;
    logic        out_ready32 = 1'b0;
    logic [31:0] out_word32;
    logic [3:0]  out_tag32;
    logic [1:0]  out_mode32;

    logic        in_valid64 = 1'b0;
    logic        in_ready64;
    logic [63:0] in_word64 = '0;
    logic [1:0]  in_mode64 = '0;
    logic [3:0]  in_tag64 = '0;
    logic        out_valid64;
    logic        out_ready64 = 1'b0;
    logic [63:0] out_word64;
    logic [3:0]  out_tag64;
    logic [1:0]  out_mode64;

    sigma_unit #(.WORD_W(32), .PIPE(1), .TAG_W(4)) u_dut32 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .in_word   (in_word32),
        .in_mode   (in_mode32),
        .in_tag    (in_tag32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .out_word  (out_word32),
        .out_tag   (out_tag32),
        .out_mode  (out_mode32)
    );

    sigma_unit #(.WORD_W(64), .PIPE(2), .TAG_W(4)) u_dut64 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .in_word   (in_word64),
        .in_mode   (in_mode64),
        .in_tag    (in_tag64),
        .out_valid (out_valid64),
        .out_ready (out_ready64),
        .out_word  (out_word64),
        .out_tag   (out_tag64),
        .out_mode  (out_mode64)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int popped64 = 0;
    bit lat32 = 1'b0;
    bit lat64 = 1'b0;

    typedef struct {
        logic [63:0] word;
        logic [3:0]  tag;
        logic [1:0]  mode;
        int          cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t e32;
    exp_t e64;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    // Bit-by-bit reference rotate and shift.
    function automatic logic [63:0] ref_rot(input logic [63:0] x, input int n, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = x[(i + n) % w];
        return r;
    endfunction

    function automatic logic [63:0] ref_shr(input logic [63:0] x, input int n, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = (i + n < w) ? x[i + n] : 1'b0;
        return r;
    endfunction

    function automatic logic [63:0] ref_sigma(input logic [63:0] x, input logic [1:0] m, input int w);
        if (w == 32) begin
            case (m)
                2'd0:    return ref_rot(x, 7, 32)  ^ ref_rot(x, 18, 32) ^ ref_shr(x, 3, 32);
                2'd1:    return ref_rot(x, 17, 32) ^ ref_rot(x, 19, 32) ^ ref_shr(x, 10, 32);
                2'd2:    return ref_rot(x, 2, 32)  ^ ref_rot(x, 13, 32) ^ ref_rot(x, 22, 32);
                default: return ref_rot(x, 6, 32)  ^ ref_rot(x, 11, 32) ^ ref_rot(x, 25, 32);
            endcase
        end else begin
            case (m)
                2'd0:    return ref_rot(x, 1, 64)  ^ ref_rot(x, 8, 64)  ^ ref_shr(x, 7, 64);
                2'd1:    return ref_rot(x, 19, 64) ^ ref_rot(x, 61, 64) ^ ref_shr(x, 6, 64);
                2'd2:    return ref_rot(x, 28, 64) ^ ref_rot(x, 34, 64) ^ ref_rot(x, 39, 64);
                default: return ref_rot(x, 14, 64) ^ ref_rot(x, 18, 64) ^ ref_rot(x, 41, 64);
            endcase
        end
    endfunction

    // Monitor / scoreboard for the 32-bit instance.
    logic [31:0] hold_w32;
    logic [3:0]  hold_t32;
    logic [1:0]  hold_m32;
    bit          stall32 = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            stall32 <= 1'b0;
        end else begin
            if (stall32) begin
                check("hold32_valid", 64'(out_valid32), 64'(1));
                check("hold32_word", 64'(out_word32), 64'(hold_w32));
                check("hold32_tag", 64'(out_tag32), 64'(hold_t32));
                check("hold32_mode", 64'(out_mode32), 64'(hold_m32));
            end
            if (out_valid32 && out_ready32) begin
                if (q32.size() == 0) begin
                    check("spurious32", 64'(out_valid32), 64'(0));
                end else begin
                    e32 = q32.pop_front();
                    $display("dut32 out tag=%0d mode=%0d word=%h", out_tag32, out_mode32, out_word32);
                    check("word32", 64'(out_word32), e32.word);
                    check("tag32", 64'(out_tag32), 64'(e32.tag));
                    check("mode32", 64'(out_mode32), 64'(e32.mode));
                    if (lat32) check("lat32", 64'(cyc - e32.cyc), 64'(1));
                end
            end
            stall32  <= out_valid32 && !out_ready32;
            hold_w32 <= out_word32;
            hold_t32 <= out_tag32;
            hold_m32 <= out_mode32;
            if (in_valid32 && in_ready32)
                q32.push_back('{ref_sigma(64'(in_word32), in_mode32, 32), in_tag32, in_mode32, cyc});
        end
    end

    // Monitor / scoreboard for the 64-bit instance.
    logic [63:0] hold_w64;
    logic [3:0]  hold_t64;
    logic [1:0]  hold_m64;
    bit          stall64 = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            stall64 <= 1'b0;
        end else begin
            if (stall64) begin
                check("hold64_valid", 64'(out_valid64), 64'(1));
                check("hold64_word", out_word64, hold_w64);
                check("hold64_tag", 64'(out_tag64), 64'(hold_t64));
                check("hold64_mode", 64'(out_mode64), 64'(hold_m64));
            end
            if (out_valid64 && out_ready64) begin
                if (q64.size() == 0) begin
                    check("spurious64", 64'(out_valid64), 64'(0));
                end else begin
                    e64 = q64.pop_front();
                    popped64++;
                    $display("dut64 out tag=%0d mode=%0d word=%h", out_tag64, out_mode64, out_word64);
                    check("word64", out_word64, e64.word);
                    check("tag64", 64'(out_tag64), 64'(e64.tag));
                    check("mode64", 64'(out_mode64), 64'(e64.mode));
                    if (lat64) check("lat64", 64'(cyc - e64.cyc), 64'(2));
                end
            end
            stall64  <= out_valid64 && !out_ready64;
            hold_w64 <= out_word64;
            hold_t64 <= out_tag64;
            hold_m64 <= out_mode64;
            if (in_valid64 && in_ready64)
                q64.push_back('{ref_sigma(in_word64, in_mode64, 64), in_tag64, in_mode64, cyc});
        end
    end

    // Present one transaction and return at posedge+1 after it transfers.
    task automatic send32(input logic [31:0] w, input logic [1:0] m, input logic [3:0] t);
        bit got;
        got = 1'b0;
        in_valid32 = 1'b1; in_word32 = w; in_mode32 = m; in_tag32 = t;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (in_ready32) begin got = 1'b1; break; end
        end
        if (!got) check("send32_timeout", 64'(in_ready32), 64'(1));
        @(posedge clock); #1;
        in_valid32 = 1'b0;
    endtask

    task automatic send64(input logic [63:0] w, input logic [1:0] m, input logic [3:0] t);
        bit got;
        got = 1'b0;
        in_valid64 = 1'b1; in_word64 = w; in_mode64 = m; in_tag64 = t;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (in_ready64) begin got = 1'b1; break; end
        end
        if (!got) check("send64_timeout", 64'(in_ready64), 64'(1));
        @(posedge clock); #1;
        in_valid64 = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100; k++) begin
            @(posedge clock); #1;
            if (q32.size() == 0 && q64.size() == 0) break;
        end
        check("drain32", 64'(q32.size()), 64'(0));
        check("drain64", 64'(q64.size()), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [63:0] bp_word [6];
    int acc;
    int idx;
    int pop_base;
    int i32;
    int i64;
    logic [31:0] cw32;
    logic [63:0] cw64;
    logic [1:0]  cm32;
    logic [1:0]  cm64;

    initial begin
        for (int i = 0; i < 6; i++) bp_word[i] = {$urandom, $urandom};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid32", 64'(out_valid32), 64'(0));
        check("rst_word32", 64'(out_word32), 64'(0));
        check("rst_valid64", 64'(out_valid64), 64'(0));
        check("rst_word64", out_word64, 64'(0));
        check("rst_tag64", 64'(out_tag64), 64'(0));
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready32", 64'(in_ready32), 64'(1));
        check("rst_ready64", 64'(in_ready64), 64'(1));
        @(posedge clock); #1;

        // 32-bit, single stage: four modes back-to-back, then SHR zero-fill
        out_ready32 = 1'b1;
        lat32 = 1'b1;
        send32(32'h00000001, 2'd0, 4'd1);
        check("t32_sig0", 64'(out_word32), 64'h02004000);
        send32(32'h00000001, 2'd1, 4'd2);
        check("t32_sig1", 64'(out_word32), 64'h0000A000);
        send32(32'h00000001, 2'd2, 4'd3);
        check("t32_bsig0", 64'(out_word32), 64'h40080400);
        send32(32'h00000001, 2'd3, 4'd4);
        check("t32_bsig1", 64'(out_word32), 64'h04200080);
        send32(32'h80000000, 2'd0, 4'd5);
        check("t32_shr_fill", 64'(out_word32), 64'h11002000);
        wait_drain();
        lat32 = 1'b0;

        // 64-bit, two stages: latency and known value
        out_ready64 = 1'b1;
        lat64 = 1'b1;
        send64(64'h1, 2'd0, 4'hA);
        check("t64_early", 64'(out_valid64), 64'(0));
        @(posedge clock); #1;
        check("t64_sig0", out_word64, 64'h8100000000000000);
        check("t64_tag", 64'(out_tag64), 64'hA);
        for (int i = 0; i < 4; i++) send64({$urandom, $urandom}, 2'(i), 4'(i));
        wait_drain();
        lat64 = 1'b0;

        // 64-bit backpressure: out_ready low for 4 cycles while streaming
        out_ready64 = 1'b0;
        acc = 0;
        idx = 0;
        pop_base = popped64;
        for (int c = 0; c < 4; c++) begin
            in_valid64 = 1'b1; in_word64 = bp_word[idx];
            in_mode64 = 2'(idx % 4); in_tag64 = 4'(idx);
            @(negedge clock);
            if (in_ready64) begin acc++; idx++; end
            @(posedge clock); #1;
        end
        in_valid64 = 1'b0;
        check("bp_accepted", 64'(acc), 64'(2));
        check("bp_in_ready", 64'(in_ready64), 64'(0));
        out_ready64 = 1'b1;
        while (idx < 6) begin
            send64(bp_word[idx], 2'(idx % 4), 4'(idx));
            idx++;
        end
        wait_drain();
        check("bp_count", 64'(popped64 - pop_base), 64'(6));

        // Full stage with simultaneous input and output transfer
        out_ready32 = 1'b0;
        send32(32'h12345678, 2'd2, 4'h7);
        in_valid32 = 1'b1; in_word32 = 32'hCAFEF00D; in_mode32 = 2'd3; in_tag32 = 4'h8;
        out_ready32 = 1'b1;
        @(negedge clock);
        check("sim_in_ready", 64'(in_ready32), 64'(1));
        check("sim_out_valid", 64'(out_valid32), 64'(1));
        @(posedge clock); #1;
        in_valid32 = 1'b0;
        out_ready32 = 1'b0;
        @(negedge clock);
        check("sim_occupancy", 64'(out_valid32), 64'(1));
        check("sim_tag", 64'(out_tag32), 64'h8);
        @(posedge clock); #1;
        out_ready32 = 1'b1;
        wait_drain();

        // Reset with two entries in flight
        out_ready64 = 1'b0;
        send64(64'h0123456789ABCDEF, 2'd1, 4'h1);
        send64(64'hFEDCBA9876543210, 2'd3, 4'h2);
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        check("mrst_valid", 64'(out_valid64), 64'(0));
        check("mrst_word", out_word64, 64'(0));
        check("mrst_tag", 64'(out_tag64), 64'(0));
        check("mrst_mode", 64'(out_mode64), 64'(0));
        q64.delete();
        q32.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        out_ready64 = 1'b1;
        @(negedge clock);
        check("mrst_ready", 64'(in_ready64), 64'(1));
        repeat (6) @(posedge clock);
        #1;
        check("mrst_no_stale", 64'(out_valid64), 64'(0));

        // Random traffic with random backpressure on both instances
        i32 = 0; i64 = 0;
        cw32 = $urandom; cw64 = {$urandom, $urandom};
        cm32 = 2'($urandom_range(0, 3)); cm64 = 2'($urandom_range(0, 3));
        for (int c = 0; c < 400 && (i32 < 20 || i64 < 20); c++) begin
            out_ready32 = 1'($urandom_range(0, 1));
            out_ready64 = 1'($urandom_range(0, 1));
            in_valid32 = (i32 < 20) && ($urandom_range(0, 3) != 0);
            in_word32 = cw32; in_mode32 = cm32; in_tag32 = 4'(i32);
            in_valid64 = (i64 < 20) && ($urandom_range(0, 3) != 0);
            in_word64 = cw64; in_mode64 = cm64; in_tag64 = 4'(i64);
            @(negedge clock);
            if (in_valid32 && in_ready32) begin
                i32++; cw32 = $urandom; cm32 = 2'($urandom_range(0, 3));
            end
            if (in_valid64 && in_ready64) begin
                i64++; cw64 = {$urandom, $urandom}; cm64 = 2'($urandom_range(0, 3));
            end
            @(posedge clock); #1;
        end
        in_valid32 = 1'b0;
        in_valid64 = 1'b0;
        out_ready32 = 1'b1;
        out_ready64 = 1'b1;
        check("rand_sent32", 64'(i32), 64'(20));
        check("rand_sent64", 64'(i64), 64'(20));
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
